// File: rtl/perfmon_pkg.sv
// Shared types and constants for the pipeline performance monitor.
package perfmon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } perfStateT;

  localparam logic MODE_CUMUL    = 1'b0;
  localparam logic MODE_INTERVAL = 1'b1;

  // Read-select value that addresses the free-running cycle counter.
  localparam int SEL_CYCLES = 0;

endpackage

// File: rtl/perf_counter_ch.sv
// One event counter with its window snapshot and sticky overflow flag.
// Build option PERFMON_SATURATE_EN: saturate at all-ones instead of wrapping.
module perf_counter_ch #(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  input  logic             restart,
  input  logic             snap,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] snapVal,
  output logic             ovf
);

  logic             step;
  logic             atMax;
  logic [CNT_W-1:0] nextCount;

  assign step  = en && inc;
  assign atMax = &count;

  always_comb begin
    // NOTE: default assigned before any branch so no path leaves nextCount unassigned (no latch).
    nextCount = count;
    if (step) begin
`ifdef PERFMON_SATURATE_EN
      if (!atMax) nextCount = count + CNT_W'(1);
`else
      nextCount = count + CNT_W'(1);
`endif
    end
  end

  // The snapshot captures nextCount so the boundary cycle's own increment is included.
  always_ff @(posedge Clk) begin
    // NOTE: snapshots are plain flops rather than a RAM, so they are reset like any other state.
    if (Rst || clr) begin
      count   <= '0;
      snapVal <= '0;
      ovf     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (snap) snapVal <= nextCount;
      count <= restart ? '0 : nextCount;
      if (step && atMax) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Multi-channel cycle/event monitor with windowed snapshots and a registered read port.
// Build option PERFMON_SATURATE_EN selects saturating counters (see perf_counter_ch).
module pipeline_perf_monitor
  import perfmon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int WINDOW = 1000
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Start,
  input  logic                         Stop,
  input  logic                         Clear,
  input  logic                         Mode,
  input  logic [NUM_CH-1:0]            Events,
  input  logic [$clog2(NUM_CH+1)-1:0]  RdSel,
  input  logic                         RdSnap,
  output logic [CNT_W-1:0]             RdData,
  output logic                         WindowTick,
  output logic                         Running,
  output logic [NUM_CH:0]              Overflow
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int SEL_W = $clog2(NUM_CH+1);

  perfStateT        state, nextState;
  logic             running;
  logic             boundary;
  logic             restart;
  logic             modeLat;
  logic [WIN_W-1:0] winCnt;
  logic [CNT_W-1:0] cntVal  [NUM_CH+1];
  logic [CNT_W-1:0] snapVal [NUM_CH+1];
  logic [CNT_W-1:0] rdNext;

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  // Stop outranks Start; Clear only zeroes data and never moves the FSM.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   if (Start && !Stop) nextState = ST_RUN;
      ST_RUN:    if (Stop)           nextState = ST_FROZEN;
      ST_FROZEN: if (Start && !Stop) nextState = ST_RUN;
      default:                       nextState = ST_IDLE;
    endcase
  end

  assign running  = (state == ST_RUN);
  assign Running  = running;
  assign boundary = running && !Clear && (winCnt == WIN_W'(WINDOW - 1));
  assign restart  = boundary && (modeLat == MODE_INTERVAL);

  always_ff @(posedge Clk) begin
    if (Rst || Clear)  winCnt <= '0;
    else if (boundary) winCnt <= '0;
    else if (running)  winCnt <= winCnt + WIN_W'(1);
  end

  // Mode is only sampled at a boundary or Clear so a window never mixes both behaviours.
  always_ff @(posedge Clk) begin
    if (Rst)                    modeLat <= MODE_CUMUL;
    else if (Clear || boundary) modeLat <= Mode;
  end

  always_ff @(posedge Clk) begin
    if (Rst) WindowTick <= 1'b0;
    else     WindowTick <= boundary;
  end

  for (genvar i = 0; i <= NUM_CH; i++) begin : gCh
    logic incBit;
    if (i == SEL_CYCLES) begin : gCyc
      assign incBit = 1'b1;
    end else begin : gEvt
      assign incBit = Events[i-1];
    end

    perf_counter_ch #(.CNT_W(CNT_W)) uCnt (
      .Clk     (Clk),
      .Rst     (Rst),
      .en      (running),
      .inc     (incBit),
      .clr     (Clear),
      .restart (restart),
      .snap    (boundary),
      .count   (cntVal[i]),
      .snapVal (snapVal[i]),
      .ovf     (Overflow[i])
    );
  end

  // Unmatched selects (above NUM_CH) fall through to zero.
  always_comb begin
    rdNext = '0;
    for (int i = 0; i <= NUM_CH; i++) begin
      if (RdSel == SEL_W'(i)) rdNext = RdSnap ? snapVal[i] : cntVal[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) RdData <= '0;
    else     RdData <= rdNext;
  end

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed bench for pipeline_perf_monitor: a 32-bit instance plus an 8-bit instance for overflow.
module tb_pipeline_perf_monitor;

  logic        Clk = 1'b0;
  logic        Rst, Start, Stop, Clear, Mode, RdSnap;
  logic [3:0]  Events;
  logic [2:0]  RdSel;
  logic [31:0] RdData;
  logic        WindowTick, Running;
  logic [4:0]  Overflow;
  logic [7:0]  sRdData;
  logic        sWindowTick, sRunning;
  logic [4:0]  sOverflow;

  int testsRun    = 0;
  int testsFailed = 0;
  int tickCount;
  int tickAt;

  always #5 Clk = ~Clk;

  pipeline_perf_monitor #(.NUM_CH(4), .CNT_W(32), .WINDOW(1000)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .Clear(Clear), .Mode(Mode),
    .Events(Events), .RdSel(RdSel), .RdSnap(RdSnap), .RdData(RdData),
    .WindowTick(WindowTick), .Running(Running), .Overflow(Overflow)
  );

  pipeline_perf_monitor #(.NUM_CH(4), .CNT_W(8), .WINDOW(1000)) dutSmall (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .Clear(Clear), .Mode(Mode),
    .Events(Events), .RdSel(RdSel), .RdSnap(RdSnap), .RdData(sRdData),
    .WindowTick(sWindowTick), .Running(sRunning), .Overflow(sOverflow)
  );

  // Advance one edge and settle just after it.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Start = 0; Stop = 0; Clear = 0; Mode = 0;
    Events = '0; RdSel = '0; RdSnap = 0;
    cyc(); cyc();
    Rst = 1'b0;
    if (RdData !== 32'd0) begin $display("FAIL reset_rddata: got %0d want 0", RdData); testsFailed++; end
    testsRun++;
    if (WindowTick !== 1'b0) begin $display("FAIL reset_tick: got %b want 0", WindowTick); testsFailed++; end
    testsRun++;
    if (Running !== 1'b0) begin $display("FAIL reset_running: got %b want 0", Running); testsFailed++; end
    testsRun++;
    if (Overflow !== 5'd0) begin $display("FAIL reset_overflow: got %b want 00000", Overflow); testsFailed++; end
    testsRun++;
    // IDLE does not count cycles.
    cyc(); cyc();
    if (RdData !== 32'd0) begin $display("FAIL reset_idle_cycles: got %0d want 0", RdData); testsFailed++; end
    testsRun++;
  endtask

  // Start edge, then 1000 RUN edges: the tick follows the 1000th.
  task automatic test_window_tick();
    Start = 1'b1; cyc(); Start = 1'b0;
    if (Running !== 1'b1) begin $display("FAIL t1_running: got %b want 1", Running); testsFailed++; end
    testsRun++;
    tickCount = 0; tickAt = 0;
    for (int k = 1; k <= 1002; k++) begin
      cyc();
      if (WindowTick === 1'b1) begin tickCount++; tickAt = k; end
    end
    if (tickCount !== 1) begin $display("FAIL t1_tick_count: got %0d want 1", tickCount); testsFailed++; end
    testsRun++;
    if (tickAt !== 1000) begin $display("FAIL t1_tick_edge: got %0d want 1000", tickAt); testsFailed++; end
    testsRun++;
    Stop = 1'b1; cyc(); Stop = 1'b0;   // 1003rd counted edge
    RdSel = 3'd0; RdSnap = 1'b1; cyc();
    if (RdData !== 32'd1000) begin $display("FAIL t1_snap_cycles: got %0d want 1000", RdData); testsFailed++; end
    testsRun++;
    RdSnap = 1'b0; cyc();
    if (RdData !== 32'd1003) begin $display("FAIL t1_live_frozen: got %0d want 1003", RdData); testsFailed++; end
    testsRun++;
  endtask

  // Events[0] on odd RUN edges: 500 per window, cumulative snapshots 500 then 1000.
  task automatic test_cumulative();
    Mode = 1'b0; Clear = 1'b1; Start = 1'b1; cyc(); Clear = 1'b0; Start = 1'b0;
    RdSel = 3'd0; RdSnap = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      Events = {3'b000, (k % 2) == 1};
      cyc();
      if (k == 1000) begin
        if (RdData !== 32'd999) begin $display("FAIL t2_read_latency: got %0d want 999", RdData); testsFailed++; end
        testsRun++;
        RdSel = 3'd1; RdSnap = 1'b1;
      end
      if (k == 1001) begin
        if (RdData !== 32'd500) begin $display("FAIL t2_snap_win1: got %0d want 500", RdData); testsFailed++; end
        testsRun++;
      end
      if (k == 2000) begin
        if (RdData !== 32'd500) begin $display("FAIL t2_boundary_read_pre: got %0d want 500", RdData); testsFailed++; end
        testsRun++;
      end
    end
    Events = '0;
    Stop = 1'b1; cyc(); Stop = 1'b0;
    if (RdData !== 32'd1000) begin $display("FAIL t2_snap_win2: got %0d want 1000", RdData); testsFailed++; end
    testsRun++;
    RdSel = 3'd0; cyc();
    if (RdData !== 32'd2000) begin $display("FAIL t2_snap_cycles: got %0d want 2000", RdData); testsFailed++; end
    testsRun++;
  endtask

  // Interval mode: Events[2] high for the first window only.
  task automatic test_interval();
    Mode = 1'b1; Clear = 1'b1; Start = 1'b1; cyc(); Clear = 1'b0; Start = 1'b0;
    Events = 4'b0100; RdSel = 3'd0; RdSnap = 1'b0;
    repeat (1000) cyc();
    Events = '0; RdSel = 3'd3;
    cyc();
    if (RdData !== 32'd0) begin $display("FAIL t3_live_restart: got %0d want 0", RdData); testsFailed++; end
    testsRun++;
    RdSnap = 1'b1; cyc();
    if (RdData !== 32'd1000) begin $display("FAIL t3_snap_win1: got %0d want 1000", RdData); testsFailed++; end
    testsRun++;
    repeat (998) cyc();                // second boundary on the last of these
    Stop = 1'b1; cyc(); Stop = 1'b0; Mode = 1'b0;
    if (RdData !== 32'd0) begin $display("FAIL t3_snap_win2: got %0d want 0", RdData); testsFailed++; end
    testsRun++;
    RdSel = 3'd0; cyc();
    if (RdData !== 32'd1000) begin $display("FAIL t3_snap_cycles: got %0d want 1000", RdData); testsFailed++; end
    testsRun++;
    RdSnap = 1'b0; cyc();
    if (RdData !== 32'd1) begin $display("FAIL t3_live_cycles: got %0d want 1", RdData); testsFailed++; end
    testsRun++;
  endtask

  // 300 RUN edges, freeze with events active, resume: 700 more RUN edges to the tick.
  task automatic test_stop_resume();
    Clear = 1'b1; Start = 1'b1; cyc(); Clear = 1'b0; Start = 1'b0;
    repeat (299) cyc();
    Stop = 1'b1; cyc(); Stop = 1'b0;
    Events = 4'hF; RdSel = 3'd0; RdSnap = 1'b0; tickCount = 0;
    repeat (50) begin
      cyc();
      if (WindowTick === 1'b1) tickCount++;
    end
    if (RdData !== 32'd300) begin $display("FAIL t4_frozen_cycles: got %0d want 300", RdData); testsFailed++; end
    testsRun++;
    RdSel = 3'd1; cyc();
    if (RdData !== 32'd0) begin $display("FAIL t4_frozen_events: got %0d want 0", RdData); testsFailed++; end
    testsRun++;
    RdSel = 3'd5; cyc();
    if (RdData !== 32'd0) begin $display("FAIL t4_sel_out_of_range: got %0d want 0", RdData); testsFailed++; end
    testsRun++;
    Events = '0; Start = 1'b1; cyc(); Start = 1'b0;
    tickAt = 0;
    for (int j = 1; j <= 701; j++) begin
      cyc();
      if (WindowTick === 1'b1) begin tickCount++; tickAt = j; end
    end
    if (tickCount !== 1 || tickAt !== 700) begin
      $display("FAIL t4_resume_tick: got count %0d at %0d want count 1 at 700", tickCount, tickAt); testsFailed++;
    end
    testsRun++;
    Stop = 1'b1; cyc(); Stop = 1'b0;
    RdSel = 3'd0; RdSnap = 1'b1; cyc();
    if (RdData !== 32'd1000) begin $display("FAIL t4_snap_cycles: got %0d want 1000", RdData); testsFailed++; end
    testsRun++;
  endtask

  task automatic test_rst_mid_window();
    Start = 1'b1; cyc(); Start = 1'b0;
    repeat (100) cyc();
    Rst = 1'b1; cyc(); Rst = 1'b0;
    if (Running !== 1'b0 || WindowTick !== 1'b0) begin
      $display("FAIL rst_mid_state: got running %b tick %b want 0 0", Running, WindowTick); testsFailed++;
    end
    testsRun++;
    RdSel = 3'd0; RdSnap = 1'b1; cyc();
    if (RdData !== 32'd0) begin $display("FAIL rst_mid_snap: got %0d want 0", RdData); testsFailed++; end
    testsRun++;
  endtask

  task automatic test_clear_start_stop();
    Stop = 1'b1; Start = 1'b1; cyc(); Stop = 1'b0; Start = 1'b0;
    if (Running !== 1'b0) begin $display("FAIL t5_idle_stop_start: got %b want 0", Running); testsFailed++; end
    testsRun++;
    Clear = 1'b1; Start = 1'b1; cyc(); Clear = 1'b0; Start = 1'b0;
    if (Running !== 1'b1) begin $display("FAIL t5_clear_start_idle: got %b want 1", Running); testsFailed++; end
    testsRun++;
    repeat (20) cyc();
    Clear = 1'b1; cyc(); Clear = 1'b0;
    if (Running !== 1'b1) begin $display("FAIL t5_clear_keeps_run: got %b want 1", Running); testsFailed++; end
    testsRun++;
    RdSel = 3'd0; RdSnap = 1'b0; cyc();
    if (RdData !== 32'd0) begin $display("FAIL t5_clear_zero: got %0d want 0", RdData); testsFailed++; end
    testsRun++;
    cyc();
    if (RdData !== 32'd1) begin $display("FAIL t5_clear_restart: got %0d want 1", RdData); testsFailed++; end
    testsRun++;
    Stop = 1'b1; Start = 1'b1; cyc(); Stop = 1'b0; Start = 1'b0;
    if (Running !== 1'b0) begin $display("FAIL t5_run_stop_start: got %b want 0", Running); testsFailed++; end
    testsRun++;
    Clear = 1'b1; Start = 1'b1; cyc(); Clear = 1'b0; Start = 1'b0;
    if (Running !== 1'b1) begin $display("FAIL t5_clear_start_frozen: got %b want 1", Running); testsFailed++; end
    testsRun++;
    cyc();
    if (RdData !== 32'd0) begin $display("FAIL t5_clear_start_zero: got %0d want 0", RdData); testsFailed++; end
    testsRun++;
  endtask

  // 8-bit instance: 260 hits on Events[1] and 261 counted cycles both pass all-ones.
  task automatic test_overflow();
    logic [7:0] expCh1;
`ifdef PERFMON_SATURATE_EN
    expCh1 = 8'd255;
`else
    expCh1 = 8'd4;
`endif
    Clear = 1'b1; Start = 1'b1; cyc(); Clear = 1'b0; Start = 1'b0;
    Events = 4'b0010;
    repeat (260) cyc();
    Events = '0;
    Stop = 1'b1; cyc(); Stop = 1'b0;
    RdSel = 3'd2; RdSnap = 1'b0; cyc();
    if (sRdData !== expCh1) begin $display("FAIL t6_small_count: got %0d want %0d", sRdData, expCh1); testsFailed++; end
    testsRun++;
    if (sOverflow !== 5'b00101) begin $display("FAIL t6_small_overflow: got %b want 00101", sOverflow); testsFailed++; end
    testsRun++;
    if (RdData !== 32'd260) begin $display("FAIL t6_wide_count: got %0d want 260", RdData); testsFailed++; end
    testsRun++;
    if (Overflow !== 5'd0) begin $display("FAIL t6_wide_overflow: got %b want 00000", Overflow); testsFailed++; end
    testsRun++;
    Clear = 1'b1; cyc(); Clear = 1'b0;
    if (sOverflow !== 5'd0) begin $display("FAIL t6_clear_overflow: got %b want 00000", sOverflow); testsFailed++; end
    testsRun++;
  endtask

  initial begin
    test_reset();
    test_window_tick();
    test_cumulative();
    test_interval();
    test_stop_resume();
    test_rst_mid_window();
    test_clear_start_stop();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
